cpx_add_scheduler: RTL and testbench
====================================

// Module: cpx_add_scheduler
// PURPOSE
//  Shares one registered complex adder (complex_adder, 1-cycle latency) among NREQ requesters.
//  Each requester offers a packed operand pair {a,b} on a valid/ready port.
//  A round-robin arbiter issues at most one pair per cycle into the adder.
//  Results return on a single tagged valid/ready stream through a credit-guarded output FIFO.
// PARAMETERS
//  WID    58  packed complex operand width: imag = [WID-1:WID/2], real = [WID/2-1:0]; WID even
//  NREQ   4   number of requesters, 2..8
//  DEPTH  4   result FIFO entries; >=3 gives full throughput; must be a power of 2
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  req_valid  in   NREQ       requester i offers a pair
//  req_ready  out  NREQ       requester i pair accepted this cycle (one-hot or zero)
//  req_a      in   NREQ*WID   operand A of requester i at [i*WID +: WID]
//  req_b      in   NREQ*WID   operand B, same packing
//  res_valid  out  1          result FIFO head valid
//  res_ready  in   1          consumer accepts head
//  res_data   out  WID+2      {imag sum[WID/2:0], real sum[WID/2:0]}, as produced by complex_adder
//  res_id     out  IDW        requester index of head; IDW = clog2(NREQ)
//  busy       out  1          any pair in flight or FIFO non-empty
// BEHAVIOUR
//  Reset (async on rst high):
//   - FIFO empty; rd/wr pointers = 0; inflight = 0
//   - rr_ptr = NREQ-1, so requester 0 has top priority first
//   - res_valid = 0, res_data = 0, res_id = 0, busy = 0, req_ready = 0
//   - adder reset via ~rst
//  Credits:
//   - credit = DEPTH - count - inflight + (res_valid & res_ready); pop frees a slot the same cycle
//   - issue only when credit > 0; the FIFO can never overflow
//  Arbitration (combinational):
//   - search req_valid from rr_ptr+1 upward, wrapping mod NREQ; first hit = grant g
//   - req_ready[g] = 1 only if credit > 0; all other bits are 0
//   - handshake req_valid[g] & req_ready[g] -> rr_ptr <= g; muxed a/b drive the adder
//   - no grant -> rr_ptr holds
//   - requesters must hold valid and operands stable until ready; the block never drops a pair
//  Pipeline:
//   - handshake in cycle T -> adder output registered at end of T -> written to FIFO at end of T+1
//   - res_valid high from cycle T+2 when the FIFO is empty; latency = 2 cycles
//   - inflight bit set on issue, cleared on FIFO write; the tag (g) travels in a register beside the adder
//  Throughput:
//   - DEPTH >= 3 with res_ready held high: 1 result/cycle sustained
//  Simultaneous events:
//   - push and pop in the same cycle: count unchanged; with FIFO full this is legal
//     (pop frees the slot first by credit)
//  Backpressure:
//   - res_ready low: FIFO fills, credit reaches 0, all req_ready = 0
//   - already-issued pairs still land, guaranteed by the credit count
//  Arithmetic:
//   - no truncation; real and imag each carry 1 extra bit (WID/2+1); unsigned modulo-free sums
//  Reset mid-operation:
//   - in-flight pairs and FIFO contents are discarded; no result is emitted after rst deasserts
//     until a new handshake occurs
//  Ordering:
//   - results leave in issue order; res_id identifies the source
// STRUCTURE
//  - package cpx_pkg: WID_DEF, localparams HALF = WID/2, RES_W = WID+2, functions cpx_real/cpx_imag
//    (field slicing), clog2
//  - sub-module rr_arbiter #(NREQ): req, enable, ptr -> one-hot grant + index
//  - complex_adder instanced unchanged
//  - FIFO, credit and tag logic stay inline
// TESTING
//  1. Reset pulse mid-stream:
//     - all outputs 0 during and after reset
//     - first grant after release goes to req 0 when all valid
//  2. Single request: req 2 a={imag=1, real=2}, b={imag=3, real=4} in T
//     -> res_valid at T+2, res_data={30'd4, 30'd6}, res_id=2
//  3. All 4 valid continuously, res_ready=1 -> grants 0,1,2,3,0,...
//     - one result/cycle; res_id sequence matches grants
//  4. Carry: real 29'h1FFF_FFFF + 29'h1 and imag 29'h1FFF_FFFF + 29'h1FFF_FFFF
//     -> real 30'h2000_0000, imag 30'h3FFF_FFFE
//  5. res_ready=0 for 10 cycles, all req valid:
//     - exactly DEPTH results stored; req_ready all 0 after credit is exhausted
//     - on release, 4 results drain in order with no loss or duplication
//  6. Simultaneous pop and issue while FIFO is full:
//     - count stays at DEPTH, no overflow, data integrity holds (scoreboard)

Source files
------------

// File: rtl/cpx_pkg.sv
// Shared widths and helpers for the complex-adder scheduler slice.
package cpx_pkg;

  localparam int WID_DEF = 58;
  localparam int HALF    = WID_DEF / 2;
  localparam int RES_W   = WID_DEF + 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [HALF-1:0] cpx_real(input logic [WID_DEF-1:0] v);
    return v[HALF-1:0];
  endfunction

  function automatic logic [HALF-1:0] cpx_imag(input logic [WID_DEF-1:0] v);
    return v[WID_DEF-1:HALF];
  endfunction

endpackage

// File: rtl/complex_adder.sv
// Registered complex adder: real and imag halves each widen by one carry bit.
module complex_adder
  import cpx_pkg::*;
#(
  parameter int WID = WID_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  output logic [WID+1:0] sum
);

  localparam int H = WID / 2;

  logic [H:0]     re_d;
  logic [H:0]     im_d;
  logic [WID+1:0] sum_q;

  always_comb begin
    re_d = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]};
    im_d = {1'b0, a[WID-1:H]} + {1'b0, b[WID-1:H]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= {im_d, re_d};
  end

  assign sum = sum_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps.
module rr_arbiter
  import cpx_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    logic [IDW-1:0] k;
    k     = '0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      k = wrap_idx(ptr, off);
      if (!found && req[k]) begin
        found    = 1'b1;
        idx      = k;
        grant[k] = enable;
      end
    end
  end

endmodule

// File: rtl/cpx_add_scheduler.sv
// Shares one registered complex adder among NREQ requesters; results return
// in issue order through a FIFO whose space is reserved before each issue.
module cpx_add_scheduler
  import cpx_pkg::*;
#(
  parameter  int WID   = WID_DEF,
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 4,
  localparam int IDW   = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*WID-1:0] req_a,
  input  logic [NREQ*WID-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WID+1:0]     res_data,
  output logic [IDW-1:0]     res_id,
  output logic               busy
);

  localparam int RW = WID + 2;
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              inflight_q, inflight_d;
  logic [IDW-1:0]    tag_q, tag_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [IDW+RW-1:0] mem_q [DEPTH];

  logic              rst_n;
  logic              pop;
  logic              credit_ok;
  logic              found;
  logic              issue;
  logic [IDW-1:0]    grant_idx;
  logic [WID-1:0]    a_mux, b_mux;
  logic [RW-1:0]     sum;
  logic [IDW+RW-1:0] head;

  assign rst_n = ~rst;

  // A pop this cycle frees its slot in time for a same-cycle issue.
  assign res_valid = (count_q != '0);
  assign pop       = res_valid & res_ready;
  assign credit_ok = ((count_q + CW'(inflight_q)) < CW'(DEPTH)) | pop;
  assign issue     = found & credit_ok & ~rst;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .enable (credit_ok & ~rst),
    .ptr    (rr_ptr_q),
    .grant  (req_ready),
    .idx    (grant_idx),
    .found  (found)
  );

  always_comb begin
    a_mux = '0;
    b_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_mux = a_mux | (req_a[i*WID +: WID] & {WID{req_ready[i]}});
      b_mux = b_mux | (req_b[i*WID +: WID] & {WID{req_ready[i]}});
    end
  end

  complex_adder #(.WID(WID)) u_add (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_mux),
    .b     (b_mux),
    .sum   (sum)
  );

  always_comb begin
    rr_ptr_d   = issue ? grant_idx : rr_ptr_q;
    tag_d      = issue ? grant_idx : tag_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q + AW'(inflight_q);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q;
    if (inflight_q && !pop)      count_d = count_q + CW'(1);
    else if (!inflight_q && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= IDW'(NREQ - 1);
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (inflight_q) mem_q[wr_ptr_q] <= {tag_q, sum};
  end

  assign head     = mem_q[rd_ptr_q];
  assign res_data = res_valid ? head[RW-1:0] : '0;
  assign res_id   = res_valid ? head[IDW+RW-1:RW] : '0;
  assign busy     = inflight_q | res_valid;

endmodule

// File: tb/tb_cpx_add_scheduler.sv
// Bench for cpx_add_scheduler: vector table, directed corner sequences and a
// randomized run, all checked against a timestamped queue model of the block.
module tb_cpx_add_scheduler;
  import cpx_pkg::*;

  localparam int WID   = 58;
  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;
  localparam int RW    = WID + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*WID-1:0] req_a;
  logic [NREQ*WID-1:0] req_b;
  logic                res_valid;
  logic                res_ready;
  logic [RW-1:0]       res_data;
  logic [IDW-1:0]      res_id;
  logic                busy;

  always #5 clk = ~clk;

  cpx_add_scheduler #(.WID(WID), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  typedef struct {
    int             id;
    logic [RW-1:0]  data;
    int             ready_cyc;
  } exp_t;

  typedef struct {
    int             id;
    logic [WID-1:0] a;
    logic [WID-1:0] b;
    logic [RW-1:0]  exp;
  } vec_t;

  exp_t mq[$];
  int   m_rr;
  int   cyc;
  int   mode;
  int   dut_issues;
  int   tests_run;
  int   tests_failed;
  vec_t vecs[4];

  function automatic logic [RW-1:0] ref_sum(input logic [WID-1:0] a, input logic [WID-1:0] b);
    logic [HALF:0] re;
    logic [HALF:0] im;
    re = {1'b0, cpx_real(a)} + {1'b0, cpx_real(b)};
    im = {1'b0, cpx_imag(a)} + {1'b0, cpx_imag(b)};
    return {im, re};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    checkOutput({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    checkOutput({tag, "_res_data"},  64'(res_data),  64'd0);
    checkOutput({tag, "_res_id"},    64'(res_id),    64'd0);
    checkOutput({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  task automatic resetModel();
    mq.delete();
    m_rr = NREQ - 1;
  endtask

  task automatic randomizeSlot(input int i);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    req_a[i*WID +: WID] = t[WID-1:0];
    t = {$urandom(), $urandom()};
    req_b[i*WID +: WID] = t[WID-1:0];
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid = '0;
    req_a[v.id*WID +: WID] = v.a;
    req_b[v.id*WID +: WID] = v.b;
    req_valid[v.id] = 1'b1;
  endtask

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic stepCycle();
    int              g;
    logic            exp_valid;
    logic            pop;
    logic            credit;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    exp_valid = (mq.size() > 0) && (mq[0].ready_cyc <= cyc);
    pop       = exp_valid && res_ready;
    credit    = (mq.size() < DEPTH) || pop;
    g = -1;
    for (int off = 1; off <= NREQ; off++) begin
      int k = (m_rr + off) % NREQ;
      if (g < 0 && req_valid[k]) g = k;
    end
    exp_ready = '0;
    if (g >= 0 && credit) exp_ready[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("res_valid", 64'(res_valid), 64'(exp_valid));
    if (exp_valid) begin
      checkOutput("res_data", 64'(res_data), 64'(mq[0].data));
      checkOutput("res_id",   64'(res_id),   64'(mq[0].id));
    end
    checkOutput("busy", 64'(busy), 64'(mq.size() > 0));
    if ((req_ready & req_valid) != '0) dut_issues++;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (exp_ready != '0) begin
      mq.push_back('{g, ref_sum(req_a[g*WID +: WID], req_b[g*WID +: WID]), cyc + 2});
      m_rr = g;
    end
    cyc++;
    #1;
    if (exp_ready != '0) begin
      randomizeSlot(g);
      case (mode)
        0:       req_valid[g] = 1'b0;
        1:       req_valid[g] = 1'b1;
        default: req_valid[g] = 1'($urandom() % 2);
      endcase
    end
  endtask

  task automatic midReset(input string tag);
    rst = 1'b1;
    #2;
    checkIdle({tag, "_during"});
    @(posedge clk);
    #1;
    checkIdle({tag, "_hold"});
    resetModel();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    mode         = 1;
    dut_issues   = 0;
    rst          = 1'b1;
    res_ready    = 1'b1;
    req_a        = '0;
    req_b        = '0;
    for (int i = 0; i < NREQ; i++) randomizeSlot(i);
    req_valid    = '1;
    resetModel();

    vecs[0] = '{2, {29'd1, 29'd2}, {29'd3, 29'd4}, {30'd4, 30'd6}};
    vecs[1] = '{1, {29'h1FFF_FFFF, 29'h1FFF_FFFF}, {29'h1FFF_FFFF, 29'h1},
                {30'h3FFF_FFFE, 30'h2000_0000}};
    vecs[2] = '{0, '0, '0, '0};
    vecs[3] = '{3, {29'h123_4567, 29'h0AB_CDEF}, {29'h1, 29'h100_0000},
                {30'h123_4568, 30'h1AB_CDEF}};

    #12;
    checkIdle("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Stream a few pairs, then pull reset while results are still in flight.
    repeat (6) stepCycle();
    midReset("mid");

    // All four requesters valid from a fresh reset: strict rotation from 0.
    for (int k = 0; k < 12; k++) begin
      checkOutput("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        checkOutput("tput_valid", 64'(res_valid), 64'd1);
        checkOutput("tput_id", 64'(res_id), 64'((k - 2) % 4));
      end
      stepCycle();
    end

    mode = 0;
    repeat (8) stepCycle();

    foreach (vecs[v]) begin
      applyStimulus(vecs[v]);
      stepCycle();
      stepCycle();
      checkOutput("tbl_valid", 64'(res_valid), 64'd1);
      checkOutput("tbl_data",  64'(res_data),  64'(vecs[v].exp));
      checkOutput("tbl_id",    64'(res_id),    64'(vecs[v].id));
      stepCycle();
      checkOutput("tbl_empty", 64'(res_valid), 64'd0);
    end

    // Consumer stalled: exactly DEPTH pairs get in, then every ready drops.
    mode       = 1;
    res_ready  = 1'b0;
    req_valid  = '1;
    dut_issues = 0;
    repeat (10) stepCycle();
    checkOutput("bp_issues", 64'(dut_issues), 64'(DEPTH));
    checkOutput("bp_ready",  64'(req_ready),  64'd0);
    mode      = 0;
    res_ready = 1'b1;
    repeat (10) stepCycle();

    // Full FIFO with pop and issue landing in the same cycles.
    mode      = 1;
    res_ready = 1'b0;
    req_valid = '1;
    repeat (6) stepCycle();
    res_ready = 1'b1;
    repeat (12) stepCycle();
    mode = 0;
    repeat (10) stepCycle();

    mode = 2;
    for (int n = 0; n < 400; n++) begin
      res_ready = ($urandom() % 4) != 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom() % 2) == 1) begin
          randomizeSlot(i);
          req_valid[i] = 1'b1;
        end
      end
      if (n == 200) midReset("rnd");
      stepCycle();
    end

    mode      = 0;
    res_ready = 1'b1;
    repeat (12) stepCycle();
    req_valid = '0;
    repeat (4) stepCycle();
    checkOutput("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
